// File: rtl/sata_cont_expander.sv
// Receive-side SATA CONT expander: replaces CONT and the junk after it with the
// repeated primitive, LANES DWORDs per clock, lane 0 earliest, 1-clk latency.
//
//   state  | meaning
//   S_PASS | DWORDs pass through; P DWORDs are captured as the held primitive
//   S_SUP  | inside a CONT burst; CONT/data (and ALIGN unless passed) -> held
`ifndef CONT_PRIM
`define CONT_PRIM 32'h9999_AA7C
`endif
`ifndef ALIGN_PRIM
`define ALIGN_PRIM 32'h7B4A_4ABC
`endif
`ifndef DWORD_IS_PRIM
`define DWORD_IS_PRIM(k) (k)
`endif

module sata_cont_expander #(
  parameter int LANES      = 1,
  parameter bit ALIGN_PASS = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic                  reset,
  input  logic                  clk,
  input  logic                  i_valid,
  input  logic [32*LANES-1:0]   i_data,
  input  logic [LANES-1:0]      i_datak,
  output logic                  o_valid,
  output logic [32*LANES-1:0]   o_data,
  output logic [LANES-1:0]      o_datak,
  output logic                  o_active,
  output logic                  o_orphan_cont,
  output logic [CNT_W-1:0]      o_cont_cnt
);

  typedef enum logic {S_PASS = 1'b0, S_SUP = 1'b1} state_t;

  localparam int SUM_W = CNT_W + 3;
  localparam logic [SUM_W-1:0] CNT_MAX = {3'b000, {CNT_W{1'b1}}};

  state_t                state_q, state_d;
  logic [31:0]           held_q, held_d;
  logic                  held_ok_q, held_ok_d;
  logic [32*LANES-1:0]   data_d;
  logic [LANES-1:0]      datak_d;
  logic                  orphan_d;
  logic [2:0]            entries;
  logic [31:0]           lane_dw;
  logic                  lane_k, is_cont, is_align, is_prim;
  logic [SUM_W-1:0]      cnt_sum;
  logic [CNT_W-1:0]      cnt_d;

  // Lanes are walked in order so each lane sees the state left by the previous one.
  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    held_ok_d = held_ok_q;
    data_d    = i_data;
    datak_d   = i_datak;
    orphan_d  = 1'b0;
    entries   = 3'd0;
    lane_dw   = 32'd0;
    lane_k    = 1'b0;
    is_cont   = 1'b0;
    is_align  = 1'b0;
    is_prim   = 1'b0;
    for (int n = 0; n < LANES; n++) begin
      lane_dw  = i_data[32*n +: 32];
      lane_k   = `DWORD_IS_PRIM(i_datak[n]);
      is_cont  = lane_k && (lane_dw == `CONT_PRIM);
      is_align = lane_k && (lane_dw == `ALIGN_PRIM);
      is_prim  = lane_k && !is_cont && !is_align;
      case (state_d)
        S_PASS: begin
          if (is_prim) begin
            held_d    = lane_dw;
            held_ok_d = 1'b1;
          end else if (is_cont) begin
            if (held_ok_d) begin
              data_d[32*n +: 32] = held_d;
              datak_d[n]         = 1'b1;
              state_d            = S_SUP;
              entries            = entries + 3'd1;
            end else begin
              orphan_d = 1'b1;
            end
          end
        end
        S_SUP: begin
          if (is_prim) begin
            held_d  = lane_dw;
            state_d = S_PASS;
          end else if (is_cont || !lane_k || (is_align && !ALIGN_PASS)) begin
            data_d[32*n +: 32] = held_d;
            datak_d[n]         = 1'b1;
          end
        end
        default: state_d = S_PASS;
      endcase
    end
    cnt_sum = {3'b000, o_cont_cnt} + SUM_W'(entries);
    cnt_d   = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_PASS;
      held_q        <= 32'd0;
      held_ok_q     <= 1'b0;
      o_valid       <= 1'b0;
      o_data        <= '0;
      o_datak       <= '0;
      o_orphan_cont <= 1'b0;
      o_cont_cnt    <= '0;
    end else if (i_valid) begin
      state_q       <= state_d;
      held_q        <= held_d;
      held_ok_q     <= held_ok_d;
      o_valid       <= 1'b1;
      o_data        <= data_d;
      o_datak       <= datak_d;
      o_orphan_cont <= orphan_d;
      o_cont_cnt    <= cnt_d;
    end else begin
      o_valid       <= 1'b0;
      o_orphan_cont <= 1'b0;
    end
  end

  assign o_active = (state_q == S_SUP);

endmodule

// File: tb/tb_sata_cont_expander.sv
// Bench for sata_cont_expander: a 1-lane and a 4-lane instance driven by directed
// and random beats, checked against a lane-by-lane behavioural model.
module tb_sata_cont_expander;

  localparam logic [31:0] CONT  = 32'h9999_AA7C;
  localparam logic [31:0] ALIGN = 32'h7B4A_4ABC;
  localparam logic [31:0] SYNC  = 32'hB5B5_957C;
  localparam logic [31:0] X_RDY = 32'h5757_B57C;
  localparam logic [31:0] SOF   = 32'h3737_B57C;
  localparam logic [31:0] R_OK  = 32'h3535_B57C;
  localparam logic [31:0] HOLD  = 32'hD5D5_AA7C;
  localparam logic [31:0] R_IP  = 32'h5555_B57C;
  localparam logic [31:0] WTRM  = 32'h5858_B57C;

  typedef struct {
    bit           sup;
    bit           ok;
    logic [31:0]  held;
    int           cnt;
    bit           valid;
    bit           orphan;
    logic [127:0] out_d;
    logic [3:0]   out_k;
  } model_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         v1 = 1'b0, v4 = 1'b0;
  logic [31:0]  d1 = '0;
  logic         k1 = 1'b0;
  logic [127:0] d4 = '0;
  logic [3:0]   k4 = '0;
  logic         ov1, ov4, oa1, oa4, oo1, oo4;
  logic [31:0]  od1;
  logic         ok1;
  logic [127:0] od4;
  logic [3:0]   ok4;
  logic [1:0]   oc1;
  logic [3:0]   oc4;

  int checks = 0;
  int errors = 0;
  model_t m1, m4;

  sata_cont_expander #(.LANES(1), .ALIGN_PASS(1'b0), .CNT_W(2)) u1 (
    .reset(reset), .clk(clk), .i_valid(v1), .i_data(d1), .i_datak(k1),
    .o_valid(ov1), .o_data(od1), .o_datak(ok1), .o_active(oa1),
    .o_orphan_cont(oo1), .o_cont_cnt(oc1));

  sata_cont_expander #(.LANES(4), .ALIGN_PASS(1'b1), .CNT_W(4)) u4 (
    .reset(reset), .clk(clk), .i_valid(v4), .i_data(d4), .i_datak(k4),
    .o_valid(ov4), .o_data(od4), .o_datak(ok4), .o_active(oa4),
    .o_orphan_cont(oo4), .o_cont_cnt(oc4));

  // Classifies each DWORD and applies the burst rules; counter is a clamped sum.
  function automatic model_t mstep(model_t m, int lanes, bit ap, int cntw,
                                   bit v, logic [127:0] d, logic [3:0] k);
    model_t r = m;
    int ent = 0;
    int mx = (1 << cntw) - 1;
    logic [31:0] dw;
    r.valid  = v;
    r.orphan = 1'b0;
    if (!v) return r;
    for (int i = 0; i < lanes; i++) begin
      dw = d[32*i +: 32];
      r.out_d[32*i +: 32] = dw;
      r.out_k[i] = k[i];
      if (k[i] && dw == CONT) begin
        if (r.sup || r.ok) begin
          r.out_d[32*i +: 32] = r.held;
          r.out_k[i] = 1'b1;
          if (!r.sup) ent++;
          r.sup = 1'b1;
        end else begin
          r.orphan = 1'b1;
        end
      end else if (k[i] && dw == ALIGN) begin
        if (r.sup && !ap) begin
          r.out_d[32*i +: 32] = r.held;
          r.out_k[i] = 1'b1;
        end
      end else if (k[i]) begin
        r.held = dw;
        r.ok   = 1'b1;
        r.sup  = 1'b0;
      end else if (r.sup) begin
        r.out_d[32*i +: 32] = r.held;
        r.out_k[i] = 1'b1;
      end
    end
    r.cnt = (r.cnt + ent > mx) ? mx : r.cnt + ent;
    return r;
  endfunction

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("u1_valid",  128'(ov1), 128'(m1.valid));
    check("u1_data",   128'(od1), 128'(m1.out_d[31:0]));
    check("u1_datak",  128'(ok1), 128'(m1.out_k[0]));
    check("u1_active", 128'(oa1), 128'(m1.sup));
    check("u1_orphan", 128'(oo1), 128'(m1.orphan));
    check("u1_cnt",    128'(oc1), 128'(m1.cnt));
    check("u4_valid",  128'(ov4), 128'(m4.valid));
    check("u4_data",   od4,       m4.out_d);
    check("u4_datak",  128'(ok4), 128'(m4.out_k));
    check("u4_active", 128'(oa4), 128'(m4.sup));
    check("u4_orphan", 128'(oo4), 128'(m4.orphan));
    check("u4_cnt",    128'(oc4), 128'(m4.cnt));
  endtask

  task automatic step(bit sv1, logic [31:0] sd1, bit sk1,
                      bit sv4, logic [127:0] sd4, logic [3:0] sk4);
    v1 = sv1; d1 = sd1; k1 = sk1; v4 = sv4; d4 = sd4; k4 = sk4;
    @(posedge clk);
    m1 = mstep(m1, 1, 1'b0, 2, sv1, {96'd0, sd1}, {3'b000, sk1});
    m4 = mstep(m4, 4, 1'b1, 4, sv4, sd4, sk4);
    #1;
    check_all();
  endtask

  task automatic s1(logic [31:0] sd1, bit sk1);
    step(1'b1, sd1, sk1, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m1 = '{default: 0};
    m4 = '{default: 0};
    #2;
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] pick_prim(int sel);
    case (sel % 6)
      0: return X_RDY;
      1: return SYNC;
      2: return HOLD;
      3: return R_IP;
      4: return WTRM;
      default: return R_OK;
    endcase
  endfunction

  task automatic rand_dw(output logic [31:0] dw, output logic k);
    int r = $urandom_range(0, 9);
    if (r < 3)      begin dw = CONT;                 k = 1'b1; end
    else if (r < 4) begin dw = ALIGN;                k = 1'b1; end
    else if (r < 6) begin dw = pick_prim($urandom);  k = 1'b1; end
    else            begin dw = $urandom;             k = 1'b0; end
  endtask

  logic [31:0] t1_exp [5];
  logic [31:0] rdw;
  logic        rk;
  logic [127:0] rd4;
  logic [3:0]  rk4;

  initial begin
    m1 = '{default: 0};
    m4 = '{default: 0};
    #1;
    do_reset();

    // Basic burst on one lane.
    t1_exp = '{X_RDY, X_RDY, X_RDY, X_RDY, SOF};
    s1(X_RDY, 1'b1);       check("t1_out0", 128'(od1), 128'(t1_exp[0]));
    s1(CONT, 1'b1);        check("t1_out1", 128'(od1), 128'(t1_exp[1]));
    check("t1_act1", 128'(oa1), 128'd1);
    s1(32'h1234_5678, 1'b0); check("t1_out2", 128'(od1), 128'(t1_exp[2]));
    s1(32'hDEAD_BEEF, 1'b0); check("t1_out3", 128'(od1), 128'(t1_exp[3]));
    s1(SOF, 1'b1);         check("t1_out4", 128'(od1), 128'(t1_exp[4]));
    check("t1_act4", 128'(oa1), 128'd0);
    check("t1_cnt", 128'(oc1), 128'd1);

    // ALIGN inside a burst, replaced on the 1-lane (mode 0) instance.
    s1(SYNC, 1'b1); s1(CONT, 1'b1);
    s1(ALIGN, 1'b1); check("t2_align0", 128'(od1), 128'(SYNC));
    s1(32'h0BAD_F00D, 1'b0); s1(R_OK, 1'b1);
    // ALIGN passed on the 4-lane (mode 1) instance.
    step(1'b0, '0, 1'b0, 1'b1, {32'h0BAD_F00D, ALIGN, CONT, SYNC}, 4'b0111);
    check("t2_align1", 128'(od4[95:64]), 128'(ALIGN));
    step(1'b0, '0, 1'b0, 1'b1, {32'h1, 32'h2, 32'h3, R_OK}, 4'b0001);

    // Orphan CONT right after reset.
    do_reset();
    s1(CONT, 1'b1);
    check("t3_orphan", 128'(oo1), 128'd1);
    check("t3_cont", 128'(od1), 128'(CONT));
    s1(32'h5A5A_5A5A, 1'b0);
    check("t3_junk", 128'(od1), 128'h5A5A_5A5A);
    check("t3_orphan_clr", 128'(oo1), 128'd0);

    // Four lanes, two beats.
    do_reset();
    step(1'b0, '0, 1'b0, 1'b1, {R_IP, 32'hCAFE_0001, CONT, HOLD}, 4'b1011);
    check("t4_beat0", od4, {R_IP, HOLD, HOLD, HOLD});
    step(1'b0, '0, 1'b0, 1'b1, {WTRM, 32'hCAFE_0003, 32'hCAFE_0002, CONT}, 4'b1001);
    check("t4_beat1", od4, {WTRM, R_IP, R_IP, R_IP});
    check("t4_cnt", 128'(oc4), 128'd2);

    // Valid gap mid-burst.
    s1(SYNC, 1'b1); s1(CONT, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, '0);
    check("t5_hold", 128'(od1), 128'(SYNC));
    s1(32'h7777_7777, 1'b0);
    check("t5_resume", 128'(od1), 128'(SYNC));

    // Reset asserted mid-burst, then orphan until a primitive is seen.
    reset = 1'b1;
    m1 = '{default: 0};
    m4 = '{default: 0};
    #2;
    check_all();
    @(negedge clk);
    reset = 1'b0;
    s1(CONT, 1'b1);
    check("t5_post_rst_orphan", 128'(oo1), 128'd1);

    // Counter saturation at CNT_W=2.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      s1(X_RDY, 1'b1);
      s1(CONT, 1'b1);
      check("t6_cnt", 128'(oc1), 128'((i < 3) ? i + 1 : 3));
    end

    // Random traffic on both instances.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rand_dw(rdw, rk);
      for (int l = 0; l < 4; l++) begin
        logic [31:0] tdw;
        logic        tk;
        rand_dw(tdw, tk);
        rd4[32*l +: 32] = tdw;
        rk4[l] = tk;
      end
      step($urandom_range(0, 4) != 0, rdw, rk, $urandom_range(0, 4) != 0, rd4, rk4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
